// File: rtl/code_pkg.sv
// Shared types and defaults for the serial code transmitter.
package code_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CODE_W_DEF = 6;
  localparam int GAP_DEF    = 10;
  localparam int BIT_IDX_W  = 4;

  // A zero-length gap still needs a 1-bit counter so the timer elaborates.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

endpackage

// File: rtl/code_gap_timer.sv
// Loadable down-counter that times the idle gap between accepted bits.
module code_gap_timer
  import code_pkg::*;
#(
  parameter int GAP = GAP_DEF
) (
  input  logic hz100,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int CW = gap_cnt_w(GAP);
  // Loading GAP-1 makes expired true on the last of the GAP idle cycles.
  localparam logic [CW-1:0] LOAD_V = CW'((GAP > 0) ? GAP - 1 : 0);

  logic [CW-1:0] r_count;

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= LOAD_V;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/code_sender.sv
// Plays a stored code out LSB-first over a valid/ready bit channel.
// Optional trailing even-parity bit when CODE_SENDER_PARITY_EN is defined.
module code_sender
  import code_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic                 hz100,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CODE_W-1:0]    load_code,
  input  logic                 start,
  input  logic                 abort,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic [CODE_W-1:0]    stored_code,
  output logic [1:0]           dbg_state
);

`ifdef CODE_SENDER_PARITY_EN
  localparam int FRAME_W = CODE_W + 1;
`else
  localparam int FRAME_W = CODE_W;
`endif

  // Handshake: a bit transfers on a rising edge where bit_valid && bit_ready.
  // bit_valid/bit_out/bit_idx are registers and never depend on bit_ready.
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CODE_W-1:0]    r_stored;
  logic [FRAME_W-1:0]   r_shift;
  logic [FRAME_W-1:0]   w_shift_nxt;
  logic [FRAME_W-1:0]   w_frame_init;
  logic [CODE_W-1:0]    w_frame_src;
  logic [BIT_IDX_W-1:0] r_idx;
  logic [BIT_IDX_W-1:0] w_idx_nxt;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_gap_load;
  logic                 w_gap_expired;

  // A load in the same cycle as start must reach the new frame.
  assign w_frame_src = load ? load_code : r_stored;

`ifdef CODE_SENDER_PARITY_EN
  assign w_frame_init = {^w_frame_src, w_frame_src};
`else
  assign w_frame_init = w_frame_src;
`endif

  assign w_xfer = r_valid && bit_ready;
  assign w_last = (r_idx == BIT_IDX_W'(FRAME_W - 1));

  code_gap_timer #(
    .GAP(GAP)
  ) u_gap_timer (
    .hz100   (hz100),
    .reset_n (reset_n),
    .load    (w_gap_load),
    .expired (w_gap_expired)
  );

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_gap_load  = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = SEND;
            w_shift_nxt = w_frame_init;
            w_idx_nxt   = '0;
          end
        end
        SEND: begin
          if (w_xfer) begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + 1'b1;
            if (w_last) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else if (GAP > 0) begin
              w_state_nxt = code_pkg::GAP;
              w_gap_load  = 1'b1;
            end
          end
        end
        code_pkg::GAP: begin
          if (w_gap_expired) begin
            w_state_nxt = SEND;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      r_stored <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (load) begin
        r_stored <= load_code;
      end
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= (w_state_nxt == SEND);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bit_out     = r_shift[0];
  assign bit_valid   = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bit_idx     = r_idx;
  assign stored_code = r_stored;
  assign dbg_state   = r_state;

endmodule
